// File: rtl/shift_mult_pkg.sv
// Shared types and constants for the signed shift-and-add multiplier controller.
package shift_mult_pkg;

    localparam int unsigned WIDTH_DEFAULT = 11;
    localparam int unsigned CNT_W = $clog2(WIDTH_DEFAULT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StSign,
        StDone
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/abs_mag.sv
// Two's-complement magnitude: the most-negative input maps to 2^(WIDTH-1) as unsigned.
module abs_mag
    import shift_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_neg
);

    assign o_neg = i_val[WIDTH-1];
    assign o_mag = o_neg ? -i_val : i_val;

endmodule

// File: rtl/shift_mult_ctrl.sv
// Sequencer for a signed shift-and-add multiplier (sign-magnitude, one iteration per clock).
// Optional SHIFT_MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are zero.
module shift_mult_ctrl
    import shift_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    localparam int unsigned PW   = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    product
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sgn;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_product;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_calc_exit;

    abs_mag #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (r_a),
        .o_mag (w_mag_a),
        .o_neg (w_neg_a)
    );

    abs_mag #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (r_b),
        .o_mag (w_mag_b),
        .o_neg (w_neg_b)
    );

`ifdef SHIFT_MULT_EARLY_TERM_EN
    assign w_calc_exit = (r_mag_b == '0) || (r_cnt == CW'(WIDTH - 1));
`else
    assign w_calc_exit = (r_cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StLoad;
            StLoad:  w_state_next = StCalc;
            StCalc:  if (w_calc_exit) w_state_next = StSign;
            StSign:  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        busy = (r_state == StLoad) || (r_state == StCalc) || (r_state == StSign);
        done = (r_state == StDone);
    end

    assign product = r_product;

    // The add is gated by mag_b[0], so an early-exit cycle with mag_b==0 leaves acc untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sgn     <= 1'b0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a <= a_in;
                        r_b <= b_in;
                    end
                end
                StLoad: begin
                    r_mag_a <= w_mag_a;
                    r_mag_b <= w_mag_b;
                    r_sgn   <= w_neg_a ^ w_neg_b;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                StCalc: begin
                    if (r_mag_b[0]) begin
                        r_acc <= r_acc + (PW'(r_mag_a) << r_cnt);
                    end
                    r_mag_b <= r_mag_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                StSign: begin
                    r_product <= r_sgn ? -r_acc : r_acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Scoreboard bench for shift_mult_ctrl: driver pushes expected products, monitor checks on done.
module tb_shift_mult_ctrl;

    localparam int W  = 11;
    localparam int PW = 2 * W;

    typedef struct {
        logic [PW-1:0] prod;
        int            acc;
        int            lat;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    exp_t q[$];
    int   cyc;
    int   n_total;
    int   n_pass;

    shift_mult_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at t=%0t",
                      name, act, act, req, req, $time);
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return PW'(sa * sb);
    endfunction

    // Edges from acceptance to the edge after which done is high.
    function automatic int exp_lat(input logic [W-1:0] b);
        longint mag;
        int     bl;
        mag = longint'($signed(b));
        if (mag < 0) mag = -mag;
        bl = 0;
        while (mag != 0) begin
            bl++;
            mag = mag >> 1;
        end
`ifdef SHIFT_MULT_EARLY_TERM_EN
        return 2 + ((bl < W) ? bl + 1 : W);
`else
        return 2 + W + 0 * bl;
`endif
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {busy, done}, 0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.prod = ref_mul(a, b);
        e.acc  = cyc;
        e.lat  = exp_lat(b);
        q.push_back(e);
        chk("busy_after_accept", busy, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("product", product, e.prod);
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    initial begin
        exp_t e;
        int   n;
        int   seen;
        int   acc0;
        n_total = 0;
        n_pass  = 0;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(11'sd5, 11'sd3);
        do_op(-11'sd7, 11'sd6);
        do_op(-11'sd1024, -11'sd1024);
        do_op(11'sd0, -11'sd5);
        do_op(11'sd5, 11'sd0);
        do_op(-11'sd1024, 11'sd1023);

        // Re-pulse start and disturb operands while the first operation is in CALC.
        do_op(11'sd100, -11'sd9);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a_in  = 11'sd7;
        b_in  = 11'sd7;
        repeat (2) @(negedge clk);
        start = 1'b0;

        // Asynchronous reset in CALC: nothing is pushed, so any done would be flagged.
        wait_idle();
        a_in  = 11'sd50;
        b_in  = -11'sd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(11'sd2, 11'sd2);

        // start held high: three back-to-back results with a one-cycle IDLE gap.
        wait_idle();
        a_in  = 11'sd3;
        b_in  = -11'sd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.prod = ref_mul(11'sd3, -11'sd3);
            e.lat  = exp_lat(-11'sd3);
            e.acc  = acc0 + k * (e.lat + 2);
            q.push_back(e);
        end
        seen = 0;
        n = 0;
        while (seen < 3 && n < 200) begin
            @(negedge clk);
            if (done) seen++;
            n++;
        end
        start = 1'b0;
        chk("held_start_dones", seen, 3);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(7) == 0) rb = '0;
            if ($urandom_range(7) == 0) ra = 11'h400;
            repeat ($urandom_range(2)) @(negedge clk);
            do_op(ra, rb);
        end

        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_mult_ctrl.md
Name: shift_mult_ctrl

Overview:
- Sequential controller for the signed shift-and-add multiplier datapath.
- Accepts two WIDTH-bit two's-complement operands on a start/busy/done handshake.
- Converts both operands to magnitude, runs one shift-add iteration per clock, then restores the sign of the product.
- Sits between the operand source and the result consumer; it is the sole sequencer of the multiplier.

Parameters:
- WIDTH, 11, operand width in bits (two's complement).
- PW, 2*WIDTH, product width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  multiplicand, signed; captured on the accepting edge.
- b_in  input  WIDTH  multiplier, signed; captured on the accepting edge.
- busy  output  1  high while an operation is in progress (LOAD, CALC, SIGN).
- done  output  1  one-cycle pulse; product valid.
- product  output  PW  signed result; holds until the next accepted start.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy=0, done=0, product=0.
  - Accumulator, shift registers, counter and sign flag all cleared.
  - Reset mid-operation aborts with no done pulse. The first start after rst deasserts is accepted normally.
- States:
  - IDLE: start=1 captures a_in, b_in, and sgn=a_in[WIDTH-1]^b_in[WIDTH-1]; go to LOAD.
  - LOAD: mag_a, mag_b = |operand| as WIDTH-bit unsigned. -2^(WIDTH-1) maps to 2^(WIDTH-1), which must not overflow. Clear acc; cnt=0; go to CALC.
  - CALC: each cycle, if mag_b[0], acc += mag_a shifted left by cnt (PW-bit add, no overflow possible). Then mag_b >>= 1 and cnt++. Leave after WIDTH iterations (cnt==WIDTH-1 on the last one).
  - SIGN: product <= sgn ? -acc : acc (PW-bit two's complement); go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Handshake:
  - Start is ignored unless state==IDLE; no queuing.
  - start held high re-triggers only after DONE→IDLE, so back-to-back operations have a 1-cycle IDLE gap.
  - busy falls on the same edge done rises.
- Latency: done is high in the cycle after edge N+WIDTH+2, where N is the edge that accepted start. For WIDTH=11, done appears 13 edges after acceptance.
- Boundaries:
  - A zero operand gives product 0 (negation of 0 is 0).
  - Most-negative × most-negative gives +2^(2*WIDTH-2), which fits in PW signed.
  - Operand inputs changing during busy have no effect.

Optional Feature:
- Macro: SHIFT_MULT_EARLY_TERM_EN.
- Defined: CALC exits to SIGN as soon as the remaining mag_b==0, including on entry (checked before the add). Latency becomes variable. Minimum is done 3 edges after acceptance when b_in=0.
- Undefined: always exactly WIDTH CALC cycles; fixed latency as above.

Decomposition:
- Package shift_mult_pkg holds:
  - state enum (IDLE, LOAD, CALC, SIGN, DONE).
  - WIDTH default.
  - counter width constant CNT_W = clog2(WIDTH+1).
- One natural sub-module: abs_mag. It is combinational, WIDTH-bit signed in, WIDTH-bit magnitude plus sign bit out, instantiated twice in LOAD.

Test Plan:
- a=5, b=3, start pulse -> busy for WIDTH+2 cycles, done pulse, product=15 (0x00000F).
- a=-7, b=6 -> product=-42 (0x3FFFD6); then a=-1024, b=-1024 -> product=1048576 (0x100000).
- a=0, b=-5 -> product=0. With SHIFT_MULT_EARLY_TERM_EN and a=5, b=0, done 3 edges after acceptance; without the macro, 13 edges.
- start re-pulsed and a_in/b_in changed mid-CALC -> ignored; product of the original operands returned, exactly one done.
- rst asserted asynchronously in CALC -> busy, done and product drop to 0 immediately, no done pulse. Next start with a=2, b=2 -> product=4.
- start held high continuously with a=3, b=-3 -> repeated -9 results, done pulses separated by one IDLE cycle.
